// File: rtl/array_skew_feeder_pkg.sv
// Shared definitions for the skew feeder and the systolic array.
// State encoding and lane packing helper.
package array_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] FEED  = 2'd2;
    localparam logic [1:0] FLUSH = 2'd3;

    function automatic int lane_lo(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/array_skew_feeder_if.sv
// Row-vector valid/ready handshake into the skew feeder.
interface array_skew_feeder_if #(
    parameter int N          = 3,
    parameter int DATA_WIDTH = 32
) ();

    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH*N-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/array_skew_feeder_skew_buffer.sv
// M x N tile store: one full-row write port, one read port per lane.
// Reads see the same-cycle write so the first FEED step needs no bubble.
module skew_buffer
    import array_pkg::*;
#(
    parameter int M  = 5,
    parameter int N  = 3,
    parameter int DW = 32,
    parameter int RW = 3,
    parameter int IW = 4
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [RW-1:0]   wr_row,
    input  logic [DW*N-1:0] wr_data,
    input  logic [IW-1:0]   rd_row [N],
    output logic [DW*N-1:0] rd_data
);

    localparam int AW = (M > 1) ? $clog2(M) : 1;

    logic [DW*N-1:0] mem_q [M];
    logic [DW*N-1:0] mem_d [M];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_row[AW-1:0]] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N; i++) begin
            if (rd_row[i] < IW'(M)) begin
                rd_data[lane_lo(i, DW) +: DW] =
                    mem_d[rd_row[i][AW-1:0]][lane_lo(i, DW) +: DW];
            end
        end
    end

endmodule

// File: rtl/array_skew_feeder.sv
// Loads an M x N tile, replays it as a diagonal wavefront, then
// drives zeros so the systolic array drains before done pulses.
module array_skew_feeder
    import array_pkg::*;
#(
    parameter int M            = 5,
    parameter int N            = 3,
    parameter int K            = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int FLUSH_CYCLES = N + K - 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    array_skew_feeder_if.slave      bus,
    output logic [DATA_WIDTH*N-1:0] X,
    output logic                    x_valid,
    output logic                    busy,
    output logic                    done
);

    localparam int RW = $clog2(M + 1);
    localparam int TW = $clog2(M + N + FLUSH_CYCLES + 1);
    // A zero-length flush still spends one cycle to show done.
    localparam int FL = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES : 1;

    localparam logic [RW-1:0] ROW_LAST  = RW'(M - 1);
    localparam logic [TW-1:0] FEED_LAST = TW'(M + N - 2);
    localparam logic [TW-1:0] STEP_LAST = TW'(M + N - 2 + FL);

    logic [1:0]              state_q, state_d;
    logic [RW-1:0]           row_q, row_d;
    logic [TW-1:0]           t_q, t_d;
    logic [DATA_WIDTH*N-1:0] x_q, x_d;
    logic                    x_valid_q, x_valid_d;
    logic                    done_q, done_d;

    logic                    wr_en;
    logic [TW-1:0]           rd_row [N];
    logic [DATA_WIDTH*N-1:0] rd_data;

    skew_buffer #(
        .M  (M),
        .N  (N),
        .DW (DATA_WIDTH),
        .RW (RW),
        .IW (TW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_row  (row_q),
        .wr_data (bus.in_data),
        .rd_row  (rd_row),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            t_q       <= '0;
            x_q       <= '0;
            x_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            t_q       <= t_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        t_d     = t_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    row_d   = '0;
                    t_d     = '0;
                end
            end
            LOAD: begin
                if (bus.in_valid) begin
                    row_d = row_q + 1'b1;
                    if (row_q == ROW_LAST) begin
                        state_d = FEED;
                        t_d     = '0;
                    end
                end
            end
            FEED: begin
                t_d = t_q + 1'b1;
                if (t_q == FEED_LAST) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (t_q == STEP_LAST) begin
                    state_d = IDLE;
                    t_d     = '0;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane i trails lane 0 by i steps; underflow lands out of range.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            rd_row[i] = t_d - TW'(i);
        end
    end

    always_comb begin
        bus.in_ready = (state_q == LOAD);
        busy         = (state_q != IDLE);
        wr_en        = (state_q == LOAD) && bus.in_valid;
        x_valid_d    = (state_d == FEED);
        x_d          = x_valid_d ? rd_data : '0;
        done_d       = (state_d == FLUSH) && (t_d == STEP_LAST);
    end

    assign X       = x_q;
    assign x_valid = x_valid_q;
    assign done    = done_q;

endmodule

// File: tb/tb_array_skew_feeder.sv
// Self-checking bench for array_skew_feeder with a wavefront model.
module tb_array_skew_feeder;

    localparam int M  = 5;
    localparam int N  = 3;
    localparam int K  = 4;
    localparam int DW = 32;
    localparam int FC = N + K - 1;
    localparam int FS = M + N - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [DW*N-1:0]   X;
    logic              x_valid;
    logic              busy;
    logic              done;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    logic [DW-1:0]   a_mat    [M][N];
    logic [DW*N-1:0] obs      [FS];
    logic [DW*N-1:0] base_obs [FS];

    array_skew_feeder_if #(.N(N), .DATA_WIDTH(DW)) bus ();

    array_skew_feeder #(
        .M(M), .N(N), .K(K), .DATA_WIDTH(DW), .FLUSH_CYCLES(FC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bus     (bus),
        .X       (X),
        .x_valid (x_valid),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    function automatic logic [DW*N-1:0] row_vec(input int r);
        logic [DW*N-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = a_mat[r][i];
        return v;
    endfunction

    function automatic logic [DW*N-1:0] rnd_vec();
        logic [DW*N-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = $urandom;
        return v;
    endfunction

    function automatic logic [DW*N-1:0] pack3(input int l0, input int l1,
                                              input int l2);
        logic [DW*N-1:0] v;
        v[0*DW +: DW] = DW'(l0);
        v[1*DW +: DW] = DW'(l1);
        v[2*DW +: DW] = DW'(l2);
        return v;
    endfunction

    task automatic fill_plan(input int off);
        for (int m = 0; m < M; m++)
            for (int i = 0; i < N; i++)
                a_mat[m][i] = DW'(off + 10*m + i + 1);
    endtask

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            n_tests++;
            if (bus.in_ready !== 1'b0 || busy !== 1'b0 || x_valid !== 1'b0 ||
                X !== '0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL idle rdy=%b busy=%b xv=%b X=%h done=%b (want 0)",
                         bus.in_ready, busy, x_valid, X, done);
            end
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = rnd_vec();
            @(posedge clk); #1;
        end
    endtask

    // One complete tile from start to the cycle after done.
    task automatic do_tile(input int gap_row, input int gap_len,
                           input bit spur, input int abort_t);
        logic [DW*N-1:0] exp_seq [FS];
        int r;
        int g;
        int load_cyc;
        for (int t = 0; t < FS; t++) exp_seq[t] = '0;
        for (int m = 0; m < M; m++)
            for (int i = 0; i < N; i++)
                exp_seq[m+i][i*DW +: DW] = a_mat[m][i];

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        r = 0;
        g = 0;
        load_cyc = 0;
        while (r < M && load_cyc < 50) begin
            n_tests++;
            if (bus.in_ready !== 1'b1 || busy !== 1'b1 || x_valid !== 1'b0 ||
                X !== '0) begin
                n_fail++;
                $display("FAIL load row=%0d rdy=%b busy=%b xv=%b X=%h",
                         r, bus.in_ready, busy, x_valid, X);
            end
            if (r == gap_row && g < gap_len) begin
                bus.in_valid = 1'b0;
                bus.in_data  = rnd_vec();
                g++;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = row_vec(r);
            end
            @(posedge clk); #1;
            load_cyc++;
            if (bus.in_valid) r++;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = rnd_vec();

        for (int t = 0; t < FS; t++) begin
            if (t == abort_t) begin
                #2 rst = 1'b0;
                #1;
                n_tests++;
                if (X !== '0 || x_valid !== 1'b0 || busy !== 1'b0 ||
                    done !== 1'b0 || bus.in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL async_reset X=%h xv=%b busy=%b done=%b (want 0)",
                             X, x_valid, busy, done);
                end
                @(posedge clk); #1;
                rst = 1'b1;
                return;
            end
            n_tests++;
            if (X !== exp_seq[t] || x_valid !== 1'b1 || busy !== 1'b1 ||
                done !== 1'b0 || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL feed t=%0d X=%h want=%h xv=%b busy=%b done=%b rdy=%b",
                         t, X, exp_seq[t], x_valid, busy, done, bus.in_ready);
            end
            obs[t] = X;
            if (spur) begin
                start        = 1'($urandom_range(0, 1));
                bus.in_valid = 1'b1;
                bus.in_data  = rnd_vec();
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        start = 1'b0;

        for (int f = 0; f < FC; f++) begin
            n_tests++;
            if (X !== '0 || x_valid !== 1'b0 || busy !== 1'b1 ||
                done !== (f == FC-1) || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL flush f=%0d X=%h xv=%b busy=%b done=%b want_done=%b",
                         f, X, x_valid, busy, done, (f == FC-1));
            end
            if (spur) start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || x_valid !== 1'b0 ||
            bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL post_tile busy=%b done=%b xv=%b rdy=%b (want 0)",
                     busy, done, x_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #3;
        n_tests++;
        if (X !== '0 || x_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset X=%h xv=%b busy=%b done=%b rdy=%b (want 0)",
                     X, x_valid, busy, done, bus.in_ready);
        end
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_basic();
        fill_plan(0);
        do_tile(-1, 0, 1'b0, -1);
        for (int t = 0; t < FS; t++) base_obs[t] = obs[t];
        n_tests++;
        if (obs[0] !== pack3(1, 0, 0)) begin
            n_fail++;
            $display("FAIL basic_t0 X=%h want=%h", obs[0], pack3(1, 0, 0));
        end
        n_tests++;
        if (obs[2] !== pack3(21, 12, 3)) begin
            n_fail++;
            $display("FAIL basic_t2 X=%h want=%h", obs[2], pack3(21, 12, 3));
        end
        n_tests++;
        if (obs[4] !== pack3(41, 32, 23)) begin
            n_fail++;
            $display("FAIL basic_t4 X=%h want=%h", obs[4], pack3(41, 32, 23));
        end
        n_tests++;
        if (obs[6] !== pack3(0, 0, 43)) begin
            n_fail++;
            $display("FAIL basic_t6 X=%h want=%h", obs[6], pack3(0, 0, 43));
        end
    endtask

    task automatic test_gaps();
        fill_plan(0);
        do_tile(2, 3, 1'b0, -1);
        for (int t = 0; t < FS; t++) begin
            n_tests++;
            if (obs[t] !== base_obs[t]) begin
                n_fail++;
                $display("FAIL gaps t=%0d X=%h want=%h", t, obs[t], base_obs[t]);
            end
        end
    endtask

    task automatic test_spurious();
        int d0;
        fill_plan(0);
        idle_cycles(3);
        d0 = done_cnt;
        do_tile(-1, 0, 1'b1, -1);
        idle_cycles(3);
        n_tests++;
        if (done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL spurious_done count=%0d want=1", done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        fill_plan(0);
        do_tile(-1, 0, 1'b0, 3);
        idle_cycles(4);
        do_tile(-1, 0, 1'b0, -1);
        for (int t = 0; t < FS; t++) begin
            n_tests++;
            if (obs[t] !== base_obs[t]) begin
                n_fail++;
                $display("FAIL after_reset t=%0d X=%h want=%h",
                         t, obs[t], base_obs[t]);
            end
        end
    endtask

    task automatic test_back_to_back();
        fill_plan(0);
        do_tile(-1, 0, 1'b0, -1);
        fill_plan(100);
        do_tile(-1, 0, 1'b0, -1);
        n_tests++;
        if (obs[2] !== pack3(121, 112, 103)) begin
            n_fail++;
            $display("FAIL b2b_t2 X=%h want=%h", obs[2], pack3(121, 112, 103));
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            for (int m = 0; m < M; m++)
                for (int i = 0; i < N; i++)
                    a_mat[m][i] = $urandom;
            do_tile($urandom_range(0, M-1), $urandom_range(0, 4),
                    1'($urandom_range(0, 1)), -1);
            idle_cycles($urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_spurious();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/array_skew_feeder.md
Name: array_skew_feeder

Overview:
- Upstream stage of the systolic `array` (M×N input matrix, N×K weights, DATA_WIDTH words).
- Accepts M input row-vectors of N lanes over a valid/ready handshake and stores the whole tile.
- Then drives `array.X` as a diagonal wavefront: lane i is delayed by i cycles, with zeros in the gaps.
- Finally streams zeros so the array's pipeline drains, then pulses `done`.

Parameters:
- M, 5, number of input row-vectors per tile.
- N, 3, lanes per vector; equals array rows.
- K, 4, array columns; used only for the flush length.
- DATA_WIDTH, 32, bits per element.
- FLUSH_CYCLES, N+K-1, zero cycles driven after the wavefront.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle tile start request; honoured only in IDLE.
- in_valid  input  1  in_data holds a valid row-vector.
- in_ready  output  1  feeder accepts a row-vector this cycle.
- in_data  input  DATA_WIDTH*N  row-vector; lane i at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- X  output  DATA_WIDTH*N  skewed lanes to `array.X`, same lane packing.
- x_valid  output  1  X carries wavefront data (FEED state).
- busy  output  1  high in LOAD, FEED and FLUSH.
- done  output  1  one-cycle pulse when the tile has been fully fed and flushed.

Behaviour:
- Reset (rst=0, async): state=IDLE, X=0, x_valid=0, busy=0, done=0, counters=0. Buffer contents are don't-care.
- Reset mid-operation aborts the tile. After release the block sits in IDLE and needs a new start.
- States: IDLE, LOAD, FEED, FLUSH.
- IDLE:
  - in_ready=0.
  - start=1 -> LOAD next cycle, row counter=0.
  - in_valid is ignored.
- LOAD:
  - in_ready=1; it is a pure function of state, with no combinational path from in_valid.
  - Each in_valid&&in_ready edge writes in_data to buf[row] and increments row.
  - The edge that accepts row M-1 moves to FEED, with step t=0.
  - in_valid gaps simply stall LOAD. start is ignored.
- FEED (exactly M+N-1 cycles, t=0..M+N-2):
  - X and x_valid are registered, and both show step t during the t-th FEED cycle.
  - Lane i = buf[t-i][i] when i <= t < i+M, else 0.
  - x_valid=1 throughout FEED. There are no stalls; the array has no enable.
- FLUSH:
  - Lasts exactly FLUSH_CYCLES cycles with X=0 and x_valid=0.
  - On the last FLUSH cycle, done=1 (registered, single cycle); the next state is IDLE.
  - FLUSH_CYCLES=0 means done is asserted in the cycle after the last FEED cycle.
- busy: high from the first LOAD cycle through the done cycle inclusive. done and busy are high together.
- Arithmetic: no arithmetic on data, only muxing.
  - Row counter width: $clog2(M+1).
  - Step counter width: $clog2(M+N+FLUSH_CYCLES+1).
  - The step counter never wraps within a tile.
- Degenerate sizes:
  - M=1: LOAD takes a single handshake.
  - N=1: no skew; FEED lasts M cycles.
- Outside FEED, X is always 0, so a stale X never reaches the array.
- start during LOAD/FEED/FLUSH is ignored, not queued.

Decomposition:
- Shared package array_pkg holds:
  - State encoding localparams: IDLE=2'd0, LOAD=2'd1, FEED=2'd2, FLUSH=2'd3.
  - Lane slice width/offset helper macros for DATA_WIDTH*lane packing, shared with `array`.
- Sub-module skew_buffer: M×N register file.
  - One write port (row index, full vector).
  - N combinational per-lane read ports (row index per lane, zero when out of range).
- The FSM and counters stay in array_skew_feeder.

Test Plan (M=5, N=3, K=4, FLUSH_CYCLES=6, A[m][i]=10m+i+1):
- Basic tile: start, 5 back-to-back rows ->
  - FEED step t=0: X lanes (0,1,2) = (1,0,0).
  - t=2: (21,12,3).
  - t=4: (41,32,23).
  - t=6: (0,0,43).
  - x_valid exactly 7 cycles, then 6 zero cycles; done on the 6th, busy low the cycle after.
- Handshake gaps: in_valid dropped for 3 cycles between rows 1 and 2 -> identical X sequence, FEED starts 3 cycles later, in_ready=1 throughout LOAD.
- Spurious inputs: start pulses during FEED, in_valid=1 in IDLE -> ignored; in_ready stays 0 outside LOAD; only one done.
- Reset mid-FEED at t=3: rst low for 1 cycle -> X=0, x_valid=0, busy=0 immediately (async); IDLE held until the next start; a following full tile matches the basic case.
- Back-to-back tiles: start asserted the cycle after done with new data A'[m][i]=100+A[m][i] -> second wavefront t=2 gives (121,112,103); no cross-tile data.
- End-to-end with `array`, W = identity-like pattern: feeder + array outputs equal the golden matrix product, checked after the flush.
